// File: rtl/bin2bcd_seq_ctrl_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional macro LEADING_ZERO_BLANK_EN enables the blank[] output, which uses blank_mask().
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DIGIT_W     = 4;
  localparam int NUM_DIGITS  = 4;
  localparam int ACC_W       = DIGIT_W * NUM_DIGITS;
  localparam int MAX_VAL_DEF = 9999;

  localparam logic [DIGIT_W-1:0] SAT_DIGIT = 4'd9;

  // A digit is blank when it and every more significant digit are zero;
  // the ones digit is never blank.
  function automatic logic [NUM_DIGITS-1:0] blank_mask(input logic [ACC_W-1:0] digits);
    logic [NUM_DIGITS-1:0] m;
    m    = '0;
    m[3] = (digits[15:12] == 4'd0);
    m[2] = m[3] && (digits[11:8] == 4'd0);
    m[1] = m[2] && (digits[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_ctrl_if.sv
// Request/result bundle between the time-keeping logic, the converter and the digit scanner.
// blank exists only when LEADING_ZERO_BLANK_EN is defined.
interface bin2bcd_seq_ctrl_if
  import bcd_pkg::*;
#(
  parameter int IN_W = 16
);

  logic               start;
  logic [IN_W-1:0]    bin_in;
  logic               busy;
  logic               done;
  logic [DIGIT_W-1:0] thousands;
  logic [DIGIT_W-1:0] hundreds;
  logic [DIGIT_W-1:0] tens;
  logic [DIGIT_W-1:0] ones;
  logic               overflow;
`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank;
`endif

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  thousands,
    input  hundreds,
    input  tens,
    input  ones,
`ifdef LEADING_ZERO_BLANK_EN
    input  blank,
`endif
    input  overflow
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output thousands,
    output hundreds,
    output tens,
    output ones,
`ifdef LEADING_ZERO_BLANK_EN
    output blank,
`endif
    output overflow
  );

endinterface

// File: rtl/bin2bcd_seq_ctrl_digit_adj.sv
// Double-dabble nibble correction: add 3 to a BCD digit that is 5 or more
// so the following left shift carries correctly into the next decade.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with start/done handshake.
// Define LEADING_ZERO_BLANK_EN to add the registered leading-zero blank[] output.
module bin2bcd_seq_ctrl
  import bcd_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  bin2bcd_seq_ctrl_if.slave bus
);

  localparam int                CNT_W     = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(IN_W - 1);
  localparam logic [IN_W-1:0]   MAX_VAL_W = IN_W'(MAX_VAL);
  localparam logic [ACC_W-1:0]  SAT_WORD  = {NUM_DIGITS{SAT_DIGIT}};

  state_e           state_q, state_d;
  logic [IN_W-1:0]  sreg_q, sreg_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  logic [ACC_W-1:0] digits_q, digits_d;
`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
`endif

  logic [ACC_W-1:0]      acc_adj;
  logic [ACC_W+IN_W-1:0] pair_shift;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (acc_q[gi*DIGIT_W +: DIGIT_W]),
      .d_o (acc_adj[gi*DIGIT_W +: DIGIT_W])
    );
  end

  // The bit leaving the top of the accumulator is dropped by the shift; it can
  // only be set for inputs above MAX_VAL, whose digits are saturated anyway.
  assign pair_shift = {acc_adj, sreg_q} << 1;

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    digits_d   = digits_q;
`ifdef LEADING_ZERO_BLANK_EN
    blank_d    = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sreg_d     = bus.bin_in;
          acc_d      = '0;
          ovf_pend_d = (bus.bin_in > MAX_VAL_W);
          cnt_d      = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        acc_d  = pair_shift[ACC_W+IN_W-1:IN_W];
        sreg_d = pair_shift[IN_W-1:0];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // Final shift: publish the completed result in one step.
          state_d    = IDLE;
          done_d     = 1'b1;
          overflow_d = ovf_pend_q;
          digits_d   = ovf_pend_q ? SAT_WORD : pair_shift[ACC_W+IN_W-1:IN_W];
`ifdef LEADING_ZERO_BLANK_EN
          blank_d    = ovf_pend_q ? '0 : blank_mask(pair_shift[ACC_W+IN_W-1:IN_W]);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      digits_q   <= '0;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q    <= 4'b1110;
`endif
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      digits_q   <= digits_d;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q    <= blank_d;
`endif
    end
  end

  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = done_q;
  assign bus.overflow  = overflow_q;
  assign bus.thousands = digits_q[15:12];
  assign bus.hundreds  = digits_q[11:8];
  assign bus.tens      = digits_q[7:4];
  assign bus.ones      = digits_q[3:0];
`ifdef LEADING_ZERO_BLANK_EN
  assign bus.blank     = blank_q;
`endif

endmodule
